// File: rtl/output_port_allocator.sv
// ---------------------------------------------------------------------------
// output_port_allocator
//   Packet allocator for one output direction of a 5-port (L,N,E,S,W) mesh
//   router. Input ports whose head flit targets this output (request == DIR)
//   are arbitrated round-robin. The winner keeps the output for its whole
//   packet, head to tail. Each flit transfer is gated on downstream credits.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-low
//   request_L..W in  3-bit destination code of the flit at each input
//   valid       in   5-bit flit-present vector (bit0=L,1=N,2=E,3=S,4=W)
//   tail        in   5-bit tail-flit vector (same bit order)
//   credit_in   in   downstream freed one buffer slot (1-cycle pulse)
//   select      out  crossbar source index 0..4; 3'b111 = none
//   grant       out  one-hot pop of the input whose flit transfers this cycle
//   xbar_en     out  a flit crosses the crossbar this cycle
//   busy        out  a packet holds the lock
//   credit_cnt  out  current downstream credit count
// ---------------------------------------------------------------------------
module output_port_allocator #(
  parameter logic [2:0] DIR     = 3'b001,
  parameter int         CREDITS = 4,
  parameter int         CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       request_L,
  input  logic [2:0]       request_N,
  input  logic [2:0]       request_E,
  input  logic [2:0]       request_S,
  input  logic [2:0]       request_W,
  input  logic [4:0]       valid,
  input  logic [4:0]       tail,
  input  logic             credit_in,
  output logic [2:0]       select,
  output logic [4:0]       grant,
  output logic             xbar_en,
  output logic             busy,
  output logic [CNT_W-1:0] credit_cnt
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] credit_q, credit_d;

  logic [4:0] cand;
  logic [2:0] winner;
  logic       found;
  logic [3:0] idx;
  logic       xfer;
  logic       has_credit;

  // Only the destination code matters for arbitration; tail is meaningful
  // only for the current owner.
  always_comb begin
    cand[0] = valid[0] && (request_L == DIR);
    cand[1] = valid[1] && (request_N == DIR);
    cand[2] = valid[2] && (request_E == DIR);
    cand[3] = valid[3] && (request_S == DIR);
    cand[4] = valid[4] && (request_W == DIR);
  end

  // Round-robin search starting at rr_ptr, wrapping modulo 5.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    idx    = 4'd0;
    for (int k = 0; k < 5; k++) begin
      idx = {1'b0, rr_ptr_q} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && cand[idx[2:0]]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

  assign has_credit = (credit_q != '0);

  always_comb begin
    grant = 5'b00000;
    if (state_q == LOCKED && valid[owner_q] && has_credit)
      grant[owner_q] = 1'b1;
  end

  assign xfer       = |grant;
  assign xbar_en    = xfer;
  assign busy       = (state_q == LOCKED);
  assign select     = (state_q == LOCKED) ? owner_q : 3'b111;
  assign credit_cnt = credit_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        // Arbitration takes a full cycle; the winner transfers next cycle.
        if (found && has_credit) begin
          state_d = LOCKED;
          owner_d = winner;
        end
      end
      LOCKED: begin
        // Pointer moves past the owner only once its packet has completed,
        // so stalls never disturb fairness.
        if (xfer && tail[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return and consumption in the same cycle cancel; returns saturate at max.
  always_comb begin
    credit_d = credit_q;
    if (xfer && !credit_in)
      credit_d = credit_q - 1'b1;
    else if (!xfer && credit_in && credit_q != CRED_MAX)
      credit_d = credit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      credit_q <= CRED_MAX;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
    end
  end

endmodule
